// File: rtl/health_bar_sprite.sv
// Health-bar overlay layer: frame-rate health/drain/flash/KO animation plus a
// two-stage pixel pipeline that turns (hcount, vcount) into a 24-bit colour (0 = transparent).
module health_bar_sprite #(
    parameter int          X_POS        = 32,
    parameter int          Y_POS        = 16,
    parameter int          MAX_HEALTH   = 128,
    parameter int          PIX_PER_HP   = 2,
    parameter int          HEIGHT       = 12,
    parameter int          DRAIN_STEP   = 2,
    parameter int          FLASH_FRAMES = 8,
    parameter logic [23:0] FILL_COLOR   = 24'h00FF00,
    parameter logic [23:0] DRAIN_COLOR  = 24'hFF0000,
    parameter logic [23:0] EMPTY_COLOR  = 24'h202020,
    parameter logic [23:0] BORDER_COLOR = 24'hFFFFFF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        new_frame_in,
    input  logic [7:0]  health_in,
    output logic [23:0] pixel_out,
    output logic        drain_busy_out,
    output logic        ko_out
);

    localparam int          W          = MAX_HEALTH * PIX_PER_HP;
    localparam logic [10:0] X_LO       = 11'(X_POS);
    localparam logic [10:0] X_HI       = 11'(X_POS + W + 1);
    localparam logic [10:0] RX_ORIGIN  = 11'(X_POS + 1);
    localparam logic [9:0]  Y_LO       = 10'(Y_POS);
    localparam logic [9:0]  Y_HI       = 10'(Y_POS + HEIGHT + 1);
    localparam logic [7:0]  MAX_HP     = 8'(MAX_HEALTH);
    localparam logic [15:0] STEP       = 16'(DRAIN_STEP);
    localparam logic [15:0] PPH        = 16'(PIX_PER_HP);
    localparam logic [7:0]  FLASH_INIT = 8'(FLASH_FRAMES);
    localparam logic [23:0] WHITE      = 24'hFFFFFF;

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_KO} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  disp_hp_reg, disp_hp_next;
    logic [7:0]  target_hp_reg;
    logic [7:0]  flash_cnt_reg, flash_cnt_next;
    logic        drain_busy_reg, ko_reg;

    logic [7:0]  clamped_hp;
    logic [7:0]  flash_dec;
    logic [7:0]  drain_to;

    logic        in_box_reg, border_reg;
    logic [10:0] rx_reg;
    logic [23:0] pixel_reg;

    logic        in_box_next, border_next;
    logic [15:0] fill_lim, disp_lim, rx_wide;
    logic [23:0] pixel_next;

    // Frame update: decide the next displayed health, flash count and state.
    always_comb begin
        clamped_hp     = (health_in > MAX_HP) ? MAX_HP : health_in;
        flash_dec      = (flash_cnt_reg != 8'd0) ? flash_cnt_reg - 8'd1 : 8'd0;
        // Step down by DRAIN_STEP but never past the target (and never below zero).
        drain_to       = ({8'd0, disp_hp_reg} > ({8'd0, clamped_hp} + STEP))
                         ? 8'(({8'd0, disp_hp_reg}) - STEP) : clamped_hp;
        disp_hp_next   = disp_hp_reg;
        flash_cnt_next = flash_cnt_reg;
        state_next     = state_reg;
        if (clamped_hp > disp_hp_reg) begin
            disp_hp_next   = clamped_hp;
            flash_cnt_next = 8'd0;
            state_next     = ST_IDLE;
        end else if (clamped_hp < disp_hp_reg) begin
            flash_cnt_next = (state_reg == ST_IDLE) ? FLASH_INIT : flash_dec;
            disp_hp_next   = drain_to;
            state_next     = (drain_to == 8'd0) ? ST_KO : ST_DRAIN;
        end else begin
            flash_cnt_next = flash_dec;
            state_next     = (disp_hp_reg == 8'd0) ? ST_KO : ST_IDLE;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg      <= ST_IDLE;
            disp_hp_reg    <= MAX_HP;
            target_hp_reg  <= MAX_HP;
            flash_cnt_reg  <= 8'd0;
            drain_busy_reg <= 1'b0;
            ko_reg         <= 1'b0;
        end else if (new_frame_in) begin
            state_reg      <= state_next;
            disp_hp_reg    <= disp_hp_next;
            target_hp_reg  <= clamped_hp;
            flash_cnt_reg  <= flash_cnt_next;
            drain_busy_reg <= (state_next == ST_DRAIN);
            ko_reg         <= (state_next == ST_KO);
        end
    end

    // Stage 1 geometry and stage 2 colour selection.
    always_comb begin
        in_box_next = (hcount_in >= X_LO) && (hcount_in <= X_HI) &&
                      (vcount_in >= Y_LO) && (vcount_in <= Y_HI);
        border_next = (hcount_in == X_LO) || (hcount_in == X_HI) ||
                      (vcount_in == Y_LO) || (vcount_in == Y_HI);
        fill_lim    = 16'(target_hp_reg) * PPH;
        disp_lim    = 16'(disp_hp_reg) * PPH;
        rx_wide     = {5'd0, rx_reg};
        if (!in_box_reg) begin
            pixel_next = 24'h000000;
        end else if (border_reg) begin
            pixel_next = (state_reg == ST_KO) ? DRAIN_COLOR : BORDER_COLOR;
        end else if (rx_wide < fill_lim) begin
            pixel_next = ((flash_cnt_reg != 8'd0) && flash_cnt_reg[1]) ? WHITE : FILL_COLOR;
        end else if (rx_wide < disp_lim) begin
            pixel_next = DRAIN_COLOR;
        end else begin
            pixel_next = EMPTY_COLOR;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            in_box_reg <= 1'b0;
            border_reg <= 1'b0;
            rx_reg     <= 11'd0;
            pixel_reg  <= 24'h000000;
        end else begin
            in_box_reg <= in_box_next;
            border_reg <= border_next;
            rx_reg     <= hcount_in - RX_ORIGIN;
            pixel_reg  <= pixel_next;
        end
    end

    assign pixel_out      = pixel_reg;
    assign drain_busy_out = drain_busy_reg;
    assign ko_out         = ko_reg;

endmodule

// File: doc/health_bar_sprite.md
Name: health_bar_sprite

Overview:
Generates one health-bar overlay layer (player or opponent) as a 24-bit pixel stream for the display compositor, where 24'h000000 means transparent.
- On each frame boundary it latches the game's health value and animates a drain segment from the previously displayed health down to the new value.
- A damage flash and a KO state are part of the animation.
- Output timing is pipelined to a fixed 2-cycle latency from pixel coordinates, matching the other overlay generators feeding the compositor.

Parameters:
X_POS, 32, left column of the bar outline (border included)
Y_POS, 16, top row of the bar outline (border included)
MAX_HEALTH, 128, full-health value; health_in is clamped to this
PIX_PER_HP, 2, interior pixels per health unit; interior width W = MAX_HEALTH*PIX_PER_HP
HEIGHT, 12, interior height in rows
DRAIN_STEP, 2, health units removed from the displayed value per frame while draining
FLASH_FRAMES, 8, frames of damage flash after a hit
FILL_COLOR, 24'h00FF00, colour of current health
DRAIN_COLOR, 24'hFF0000, colour of the segment between current and displayed health
EMPTY_COLOR, 24'h202020, colour of the empty interior (must be nonzero)
BORDER_COLOR, 24'hFFFFFF, outline colour

Ports:
clk_in  input  1  pixel clock
rst_in  input  1  asynchronous, active-high reset
hcount_in  input  11  current pixel column
vcount_in  input  10  current pixel row
new_frame_in  input  1  one-cycle pulse at the start of each frame
health_in  input  8  game health value, sampled only on new_frame_in
pixel_out  output  24  layer pixel; 0 = transparent
drain_busy_out  output  1  high while in DRAIN
ko_out  output  1  high while in KO

Behaviour:
- Reset (async, active-high):
  - disp_hp = target_hp = MAX_HEALTH, flash_cnt = 0, state = IDLE.
  - pixel pipeline registers = 0, so pixel_out = 0; drain_busy_out = 0; ko_out = 0.
  - Reset asserted mid-frame or mid-drain forces these values immediately.
- Frame update, only on a clk_in edge with new_frame_in = 1:
  - t = min(health_in, MAX_HEALTH); target_hp <= t.
  - If t > disp_hp (heal or new round): disp_hp <= t, flash_cnt <= 0, state <= IDLE. This takes priority, including exit from KO.
  - Else if t < disp_hp:
    - If state was IDLE, flash_cnt <= FLASH_FRAMES; otherwise flash_cnt <= flash_cnt - 1 (saturating at 0).
    - disp_hp <= max(t, disp_hp - DRAIN_STEP), with no unsigned underflow. Next state = DRAIN, or KO if the new disp_hp == 0.
  - Else (t == disp_hp): flash_cnt decrements (saturating at 0). State = KO if disp_hp == 0, otherwise IDLE.
  - A hit arriving during DRAIN does not restart the flash.
- States:
  - IDLE: no animation.
  - DRAIN: disp_hp > target_hp at the previous update.
  - KO: disp_hp == 0 and target_hp == 0. KO is held until health_in > 0 on a frame pulse.
- Outputs: drain_busy_out = (state == DRAIN); ko_out = (state == KO). Both are registered.
- Pixel pipeline, 2-cycle latency:
  - Stage 1 registers:
    - in_box: x in [X_POS, X_POS+W+1] and y in [Y_POS, Y_POS+HEIGHT+1].
    - is_border: first/last column or row of the box.
    - rx = x - X_POS - 1.
  - Stage 2 selects the colour using target_hp/disp_hp/flash_cnt as they stand that cycle:
    - outside box: 0.
    - border: DRAIN_COLOR if KO, else BORDER_COLOR.
    - rx < target_hp*PIX_PER_HP: FILL_COLOR, but 24'hFFFFFF when flash_cnt != 0 and flash_cnt[1] == 1.
    - rx < disp_hp*PIX_PER_HP: DRAIN_COLOR.
    - otherwise: EMPTY_COLOR.
  - Products use 16-bit unsigned width.
  - health_in changes between frame pulses have no effect on the output.

Test Plan:
- Reset, then scan a frame -> pixel_out = 0 outside the box. (x=32, y=20) -> BORDER_COLOR 2 cycles later. (x=100, y=20) -> FILL_COLOR. drain/ko = 0.
- health_in = 100 at frame pulse from 128 -> disp_hp 126, 124, ... reaches 100 after 14 frames. drain_busy_out high for exactly those 14 frames. Interior rx = 210 shows DRAIN_COLOR in frame 1 and EMPTY_COLOR after the drain completes.
- Same hit -> flash_cnt = 8, then 7, 6, ... Fill is white in frames where flash_cnt[1] = 1 (counts 7, 6, 3, 2), green otherwise.
- health_in = 1 with disp_hp = 1, then health_in = 0 -> KO entered, ko_out = 1, border = DRAIN_COLOR. health_in = 128 on a later pulse -> disp_hp = 128 immediately, state IDLE.
- health_in = 200 -> clamped: target_hp = disp_hp = 128, no drain.
- Assert rst_in asynchronously mid-drain (between clock edges) -> pixel_out = 0 and drain_busy_out = 0 before the next clock edge, disp_hp = 128 after release.
